// File: rtl/phivers_link_pkg.sv
// Shared Phivers link types: flit layout, arbiter FSM states and pointer-width helper.
// Pure declarations; no logic, no latency.
package phivers_link_pkg;

  localparam int PHIVERS_FLIT_W = 32;

  typedef struct packed {
    logic                      tx;
    logic                      eop;
    logic [PHIVERS_FLIT_W-1:0] data;
  } link_flit_t;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phivers_rr_arbiter.sv
// Round-robin picker: one-hot grant of the first request after last_i, wrapping around.
// Purely combinational (0 cycles); no backpressure of its own.
module phivers_rr_arbiter
  import phivers_link_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] last_i,
  output logic [N-1:0]  gnt_o
);

  logic found;
  int   idx;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = 0;
    // Offsets 1..N visit every requester once, ending on last_i itself.
    for (int i = 1; i <= N; i++) begin
      idx = (int'(last_i) + i) % N;
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/phivers_link_arbiter.sv
// Packet-locked round-robin share of one credit link; 1-cycle arbitration, then 0-latency pass-through.
// Only the owner sees link credit; others stall. Counters need PHIVERS_LINK_ARB_STATS_EN.
module phivers_link_arbiter
  import phivers_link_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int STAT_W = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [N_REQ-1:0]               tx_i,
  output logic [N_REQ-1:0]               cr_tx_o,
  input  logic [N_REQ-1:0]               eop_tx_i,
  input  logic [N_REQ-1:0][DATA_W-1:0]   data_tx_i,
  output logic                           rx_o,
  input  logic                           cr_rx_i,
  output logic                           eop_rx_o,
  output logic [DATA_W-1:0]              data_rx_o,
  output logic [N_REQ-1:0]               grant_o,
  output logic                           busy_o,
  output logic [N_REQ-1:0][STAT_W-1:0]   pkt_cnt_o
);

  localparam int PW = ptr_w(N_REQ);

  typedef struct packed {
    logic              tx;
    logic              eop;
    logic [DATA_W-1:0] data;
  } flit_t;

  arb_state_t        state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  rr_gnt;
  logic [PW-1:0]     last_q, last_d;
  logic [PW-1:0]     owner;
  flit_t             sel;
  logic              beat;
  logic              eop_beat;

  phivers_rr_arbiter #(.N(N_REQ)) u_rr (
    .req_i  (tx_i),
    .last_i (last_q),
    .gnt_o  (rr_gnt)
  );

  // grant_q is all-zero while idle, so this mux alone keeps the link outputs quiet.
  always_comb begin
    owner   = '0;
    sel     = '0;
    cr_tx_o = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_q[k]) begin
        owner      = PW'(k);
        sel.tx     = tx_i[k];
        sel.eop    = eop_tx_i[k];
        sel.data   = data_tx_i[k];
        cr_tx_o[k] = cr_rx_i;
      end
    end
  end

  assign rx_o      = sel.tx;
  assign eop_rx_o  = sel.eop;
  assign data_rx_o = sel.data;
  assign beat      = sel.tx && cr_rx_i;
  assign eop_beat  = beat && sel.eop;
  assign grant_o   = grant_q;
  assign busy_o    = (state_q == ARB_LOCKED);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        if (|tx_i) begin
          grant_d = rr_gnt;
          state_d = ARB_LOCKED;
        end
      end
      ARB_LOCKED: begin
        if (eop_beat) begin
          grant_d = '0;
          last_d  = owner;
          state_d = ARB_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= PW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`ifdef PHIVERS_LINK_ARB_STATS_EN
  logic [N_REQ-1:0][STAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < N_REQ; i++) begin
      if (eop_beat && grant_q[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign pkt_cnt_o = cnt_q;
`else
  assign pkt_cnt_o = '0;
`endif

endmodule
